// File: rtl/nn_pkg.sv
// Shared constants and types for the classifier back end: class count, argmax FSM states,
// and the class-index type.
package nn_pkg;
  localparam int NUM_CLASSES = 10;
  localparam int IDX_BITS    = 4;

  typedef enum logic [1:0] {IDLE, SCAN, HOLD} argmax_state_e;
  typedef logic [IDX_BITS-1:0] class_idx_t;
endpackage

// File: rtl/layer_argmax_reader.sv
// Snapshots 10 signed neuron outputs on a layer_done rising edge, scans them for the maximum.
// class_valid rises 9 cycles after capture; it holds until class_ready, and edges seen while busy set overrun.
module layer_argmax_reader
  import nn_pkg::*;
#(
  parameter int IN_BITS     = 16,
  parameter int NUM_CLASSES = nn_pkg::NUM_CLASSES,
  parameter int IDX_BITS    = nn_pkg::IDX_BITS
) (
  input  logic                                  clk,
  input  logic                                  rstn,
  input  logic [NUM_CLASSES-1:0][IN_BITS:0]     data_in,
  input  logic                                  layer_done,
  input  logic                                  class_ready,
  output logic                                  class_valid,
  output logic [IDX_BITS-1:0]                   class_idx,
  output logic [IN_BITS:0]                      class_score,
  output logic                                  busy,
  output logic                                  overrun
);

  localparam logic [IDX_BITS-1:0] LAST_IDX = IDX_BITS'(NUM_CLASSES - 1);

  argmax_state_e                   state_q;
  logic [NUM_CLASSES-1:0][IN_BITS:0] buf_q;
  logic signed [IN_BITS:0]         best_score_q;
  logic [IDX_BITS-1:0]             best_idx_q;
  logic [IDX_BITS-1:0]             scan_idx_q;
  logic                            done_d_q;
  logic                            class_valid_q;
  logic [IDX_BITS-1:0]             class_idx_q;
  logic [IN_BITS:0]                class_score_q;
  logic                            busy_q;
  logic                            overrun_q;

  logic                            trigger;
  logic signed [IN_BITS:0]         cand;
  logic                            cand_gt;

  assign trigger = layer_done & ~done_d_q;
  assign cand    = buf_q[scan_idx_q];
  // Strict compare so equal maxima keep the lowest index.
  assign cand_gt = cand > best_score_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q       <= IDLE;
      buf_q         <= '0;
      best_score_q  <= '0;
      best_idx_q    <= '0;
      scan_idx_q    <= '0;
      done_d_q      <= 1'b0;
      class_valid_q <= 1'b0;
      class_idx_q   <= '0;
      class_score_q <= '0;
      busy_q        <= 1'b0;
      overrun_q     <= 1'b0;
    end else begin
      done_d_q <= layer_done;
      // Edges outside IDLE are dropped, never replayed, including one coincident with the handshake.
      if (trigger && state_q != IDLE) begin
        overrun_q <= 1'b1;
      end
      case (state_q)
        IDLE: begin
          if (trigger) begin
            buf_q        <= data_in;
            best_score_q <= data_in[0];
            best_idx_q   <= '0;
            scan_idx_q   <= IDX_BITS'(1);
            busy_q       <= 1'b1;
            state_q      <= SCAN;
          end
        end
        SCAN: begin
          if (cand_gt) begin
            best_score_q <= cand;
            best_idx_q   <= scan_idx_q;
          end
          scan_idx_q <= scan_idx_q + 1'b1;
          if (scan_idx_q == LAST_IDX) begin
            class_idx_q   <= cand_gt ? scan_idx_q : best_idx_q;
            class_score_q <= cand_gt ? cand : best_score_q;
            class_valid_q <= 1'b1;
            busy_q        <= 1'b0;
            state_q       <= HOLD;
          end
        end
        HOLD: begin
          if (class_ready) begin
            class_valid_q <= 1'b0;
            state_q       <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign class_valid = class_valid_q;
  assign class_idx   = class_idx_q;
  assign class_score = class_score_q;
  assign busy        = busy_q;
  assign overrun     = overrun_q;

endmodule

// File: tb/tb_layer_argmax_reader.sv
module tb_layer_argmax_reader;
  logic              clk = 1'b0;
  logic              rstn;
  logic [9:0][16:0]  data_in;
  logic              layer_done;
  logic              class_ready;
  logic              class_valid;
  logic [3:0]        class_idx;
  logic [16:0]       class_score;
  logic              busy;
  logic              overrun;

  layer_argmax_reader dut (
    .clk(clk), .rstn(rstn), .data_in(data_in), .layer_done(layer_done),
    .class_ready(class_ready), .class_valid(class_valid), .class_idx(class_idx),
    .class_score(class_score), .busy(busy), .overrun(overrun)
  );

  always #5 clk = ~clk;

  typedef struct { int idx; int score; } exp_t;
  exp_t sb[$];
  int checks = 0;
  int errors = 0;
  int last_idx, last_score;
  logic signed [16:0] vec [10];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, $signed(obs), $signed(expv));
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference argmax: first strictly greater value wins.
  task automatic fire(input logic keep_high);
    exp_t e;
    e.idx = 0;
    e.score = int'(vec[0]);
    for (int i = 0; i < 10; i++) data_in[i] = vec[i];
    for (int i = 1; i < 10; i++) begin
      if (int'(vec[i]) > e.score) begin
        e.idx = i;
        e.score = int'(vec[i]);
      end
    end
    sb.push_back(e);
    layer_done = 1'b1;
    tick();
    if (!keep_high) layer_done = 1'b0;
  endtask

  task automatic expect_scan(input string tag, input int glitch_at, input int change_at);
    exp_t e;
    chk({tag, "_busy_e0"}, 32'(busy), 32'd1);
    chk({tag, "_valid_e0"}, 32'(class_valid), 32'd0);
    for (int k = 1; k <= 9; k++) begin
      if (k == glitch_at) layer_done = 1'b1;
      if (k == change_at) for (int i = 0; i < 10; i++) data_in[i] = 17'(20000 + i);
      tick();
      if (k < 9) begin
        chk({tag, "_busy_scan"}, 32'(busy), 32'd1);
        chk({tag, "_valid_scan"}, 32'(class_valid), 32'd0);
      end else begin
        chk({tag, "_valid"}, 32'(class_valid), 32'd1);
        chk({tag, "_busy_done"}, 32'(busy), 32'd0);
        if (sb.size() == 0) begin
          chk({tag, "_sb_nonempty"}, 32'd0, 32'd1);
        end else begin
          e = sb.pop_front();
          last_idx = e.idx;
          last_score = e.score;
          chk({tag, "_idx"}, 32'(class_idx), 32'(e.idx));
          chk({tag, "_score"}, 32'($signed(class_score)), 32'(e.score));
        end
      end
    end
  endtask

  task automatic handshake(input string tag);
    class_ready = 1'b1;
    tick();
    chk({tag, "_valid_drop"}, 32'(class_valid), 32'd0);
  endtask

  initial begin
    rstn = 1'b0;
    layer_done = 1'b0;
    class_ready = 1'b1;
    data_in = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", 32'(class_valid), 32'd0);
    chk("rst_idx", 32'(class_idx), 32'd0);
    chk("rst_score", 32'(class_score), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_overrun", 32'(overrun), 32'd0);
    rstn = 1'b1;
    tick();

    // Basic mixed-sign scan
    vec = '{5, -3, 9, 2, 0, 1, -8, 4, 7, 6};
    fire(1'b0);
    expect_scan("t1", 0, 0);
    handshake("t1");
    chk("t1_overrun", 32'(overrun), 32'd0);

    // Ties and all-negative data
    vec = '{-100, -100, -100, -100, -100, -100, -100, -100, -100, -100};
    fire(1'b0);
    expect_scan("tie", 0, 0);
    handshake("tie");
    vec = '{-5, -3, -9, -2, -10, -4, -8, -4, -7, -1};
    fire(1'b0);
    expect_scan("neg", 0, 0);
    handshake("neg");
    vec = '{65535, -65536, 65535, 0, -1, 1, 65534, -65536, 65535, 100};
    fire(1'b0);
    expect_scan("ext", 0, 0);
    handshake("ext");

    // Backpressure: result must hold while ready is low
    class_ready = 1'b0;
    vec = '{1, 2, 3, 4, 5, 60, 7, 8, 9, 10};
    fire(1'b0);
    expect_scan("bp", 0, 0);
    for (int c = 0; c < 20; c++) begin
      tick();
      chk("bp_valid_hold", 32'(class_valid), 32'd1);
      chk("bp_idx_hold", 32'(class_idx), 32'(last_idx));
      chk("bp_score_hold", 32'($signed(class_score)), 32'(last_score));
    end
    handshake("bp");
    vec = '{3, 3, 3, 3, 3, 3, 3, 4, 3, 3};
    fire(1'b0);
    expect_scan("bp2", 0, 0);
    handshake("bp2");

    // Second edge mid-scan is dropped and flagged
    vec = '{0, 11, -2, 33, 4, 5, 6, 7, 8, 9};
    fire(1'b0);
    expect_scan("ovr", 4, 0);
    chk("ovr_flag", 32'(overrun), 32'd1);
    handshake("ovr");
    chk("ovr_sticky", 32'(overrun), 32'd1);
    layer_done = 1'b0;
    tick();
    chk("ovr_no_retrigger", 32'(busy), 32'd0);

    // Level held high yields exactly one result
    vec = '{-7, 8, 8, -1, 2, 3, 4, 5, 6, 7};
    fire(1'b1);
    expect_scan("lvl", 0, 0);
    handshake("lvl");
    for (int c = 0; c < 50; c++) begin
      tick();
      chk("lvl_idle", {30'd0, busy, class_valid}, 32'd0);
    end
    chk("lvl_overrun", 32'(overrun), 32'd1);
    layer_done = 1'b0;
    tick();

    // Input changes mid-scan must not leak into the result
    vec = '{12, -4, 13, 2, 99, 1, 0, 98, 7, 6};
    fire(1'b0);
    expect_scan("snap", 0, 3);
    handshake("snap");

    // Async reset mid-scan aborts without output
    vec = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 77};
    fire(1'b0);
    repeat (4) tick();
    #2;
    rstn = 1'b0;
    #1;
    chk("arst_valid", 32'(class_valid), 32'd0);
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_overrun", 32'(overrun), 32'd0);
    void'(sb.pop_front());
    tick();
    #2;
    rstn = 1'b1;
    for (int c = 0; c < 15; c++) begin
      tick();
      chk("arst_quiet", {30'd0, busy, class_valid}, 32'd0);
    end
    vec = '{-1, -2, 40, -4, 40, -6, -7, -8, -9, 39};
    fire(1'b0);
    expect_scan("post_rst", 0, 0);
    handshake("post_rst");

    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
